// File: rtl/regfile_bank.sv
// Parametrised multi-port register file with prioritised dual write, auto-incrementing PC
// register and per-register pending scoreboard. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
module regfile_bank #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NREAD   = 4,
  parameter int PC_ADDR = (1 << ADDR_W) - 1,
  parameter int PC_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_pending,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pending;

  // One-hot decode of each write port and the reservation; entry 0 is never hit.
  logic [DEPTH-1:0]  w_hit0;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_rsv_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_hit0    = '0;
    w_hit1    = '0;
    w_rsv_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_hit0[i]    = wr_en[0] && (wr_addr0 == ADDR_W'(i));
      w_hit1[i]    = wr_en[1] && (wr_addr1 == ADDR_W'(i));
      w_rsv_hit[i] = rsv_en   && (rsv_addr == ADDR_W'(i));
    end
  end

  // NOTE: the array is reset explicitly because reset must clear every register, which rules
  // out RAM inference; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_hit1[i]) begin
          r_regs[i] <= wr_data1;
        end else if (w_hit0[i]) begin
          r_regs[i] <= wr_data0;
        end else if ((i == PC_ADDR) && pc_inc) begin
          r_regs[i] <= r_regs[i] + DATA_W'(PC_STEP);
        end

        // A new producer supersedes a same-cycle write, so the reservation takes priority.
        if (w_rsv_hit[i]) begin
          r_pending[i] <= 1'b1;
        end else if (w_hit0[i] || w_hit1[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign pc = r_regs[PC_ADDR];

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic w_byp0;
    logic w_byp1;
    assign w_byp0 = w_hit0[w_addr];
    assign w_byp1 = w_hit1[w_addr];
    assign rd_data[k*DATA_W +: DATA_W] = w_byp1 ? wr_data1 :
                                         w_byp0 ? wr_data0 : r_regs[w_addr];
    // A forwarded value is complete unless a new producer is reserving the same register.
    assign rd_pending[k] = (w_byp0 || w_byp1) ? w_rsv_hit[w_addr] : r_pending[w_addr];
`else
    assign rd_data[k*DATA_W +: DATA_W] = r_regs[w_addr];
    assign rd_pending[k]               = r_pending[w_addr];
`endif
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed vector table, hand-written reset and
// forwarding sequences, then randomized traffic compared against an array-based model.
module tb_regfile_bank;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int PCA = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pending;
  logic [1:0]       wr_en = '0;
  logic [AW-1:0]    wr_addr0 = '0, wr_addr1 = '0;
  logic [DW-1:0]    wr_data0 = '0, wr_data1 = '0;
  logic             pc_inc = 1'b0;
  logic [DW-1:0]    pc;
  logic             rsv_en = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;

  regfile_bank #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .PC_ADDR(PCA), .PC_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .pc_inc(pc_inc), .pc(pc), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural register values and pending flags.
  logic [DW-1:0] m_regs [16];
  logic          m_pend [16];

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          inc;
    logic          rsv;
    logic [AW-1:0] ra;
    logic [AW-1:0] chk;
    logic [DW-1:0] exp_data;
    logic          exp_pend;
    logic [DW-1:0] exp_pc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] we, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic inc,
                              input logic rsv, input logic [AW-1:0] ra, input logic [AW-1:0] chk,
                              input logic [DW-1:0] ed, input logic ep, input logic [DW-1:0] epc);
    vec_t v;
    v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.inc = inc;
    v.rsv = rsv; v.ra = ra; v.chk = chk; v.exp_data = ed; v.exp_pend = ep; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    pc_inc = 1'b0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Apply the architectural rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic pc_written;
    pc_written = (wr_en[0] && wr_addr0 == AW'(PCA)) || (wr_en[1] && wr_addr1 == AW'(PCA));
    if (pc_inc && !pc_written) m_regs[PCA] = m_regs[PCA] + 32'd1;
    if (wr_en[0] && wr_addr0 != 0) begin m_regs[wr_addr0] = wr_data0; m_pend[wr_addr0] = 1'b0; end
    if (wr_en[1] && wr_addr1 != 0) begin m_regs[wr_addr1] = wr_data1; m_pend[wr_addr1] = 1'b0; end
    if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  // Expected combinational read of one port given the model and current inputs.
  task automatic exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic p);
    d = m_regs[a];
    p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && wr_en[1] && wr_addr1 == a) begin
      d = wr_data1; p = rsv_en && rsv_addr == a;
    end else if (a != 0 && wr_en[0] && wr_addr0 == a) begin
      d = wr_data0; p = rsv_en && rsv_addr == a;
    end
`endif
  endtask

  task automatic check_ports_vs_model(input string tag);
    logic [DW-1:0] d;
    logic          p;
    for (int k = 0; k < NR; k++) begin
      exp_read(rd_addr[k*AW +: AW], d, p);
      check($sformatf("%s data[%0d]", tag, k), rd_data[k*DW +: DW], d);
      check($sformatf("%s pend[%0d]", tag, k), {31'd0, rd_pending[k]}, {31'd0, p});
    end
    check($sformatf("%s pc", tag), pc, m_regs[PCA]);
  endtask

  initial begin
    logic [DW-1:0] exp_byp;

    vecs[0]  = mk(2'b01, 4'd1,  32'd5,        4'd0, 32'd0,  1'b0, 1'b0, 4'd0, 4'd1,  32'd5,        1'b0, 32'd0);
    vecs[1]  = mk(2'b01, 4'd2,  32'd7,        4'd0, 32'd0,  1'b0, 1'b0, 4'd0, 4'd2,  32'd7,        1'b0, 32'd0);
    vecs[2]  = mk(2'b11, 4'd3,  32'd12,       4'd3, 32'd9,  1'b0, 1'b0, 4'd0, 4'd3,  32'd9,        1'b0, 32'd0);
    vecs[3]  = mk(2'b01, 4'd0,  32'hFFFF,     4'd0, 32'd0,  1'b0, 1'b0, 4'd0, 4'd0,  32'd0,        1'b0, 32'd0);
    vecs[4]  = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b1, 1'b0, 4'd0, 4'd15, 32'd1,        1'b0, 32'd1);
    vecs[5]  = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b1, 1'b0, 4'd0, 4'd15, 32'd2,        1'b0, 32'd2);
    vecs[6]  = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b1, 1'b0, 4'd0, 4'd15, 32'd3,        1'b0, 32'd3);
    vecs[7]  = mk(2'b01, 4'd15, 32'hFFFFFFFF, 4'd0, 32'd0,  1'b1, 1'b0, 4'd0, 4'd15, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
    vecs[8]  = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b1, 1'b0, 4'd0, 4'd15, 32'd0,        1'b0, 32'd0);
    vecs[9]  = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b0, 1'b1, 4'd4, 4'd4,  32'd0,        1'b1, 32'd0);
    vecs[10] = mk(2'b01, 4'd4,  32'd20,       4'd0, 32'd0,  1'b0, 1'b0, 4'd0, 4'd4,  32'd20,       1'b0, 32'd0);
    vecs[11] = mk(2'b10, 4'd0,  32'd0,        4'd4, 32'd21, 1'b0, 1'b1, 4'd4, 4'd4,  32'd21,       1'b1, 32'd0);
    vecs[12] = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b0, 1'b1, 4'd0, 4'd0,  32'd0,        1'b0, 32'd0);
    vecs[13] = mk(2'b10, 4'd6,  32'd99,       4'd6, 32'hABCD, 1'b0, 1'b0, 4'd0, 4'd6, 32'hABCD,    1'b0, 32'd0);
    vecs[14] = mk(2'b00, 4'd0,  32'd0,        4'd0, 32'd0,  1'b0, 1'b1, 4'd1, 4'd1,  32'd5,        1'b1, 32'd0);

    // Reset state
    model_reset();
    idle();
    rd_addr = {4'd15, 4'd3, 4'd2, 4'd1};
    #12;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("reset data[%0d]", k), rd_data[k*DW +: DW], 32'd0);
      check($sformatf("reset pend[%0d]", k), {31'd0, rd_pending[k]}, 32'd0);
    end
    check("reset pc", pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table: drive, clock, then read the checked register on every port
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr0 = vecs[i].a0; wr_data0 = vecs[i].d0;
      wr_addr1 = vecs[i].a1; wr_data1 = vecs[i].d1; pc_inc = vecs[i].inc;
      rsv_en = vecs[i].rsv; rsv_addr = vecs[i].ra;
      rd_addr = {NR{vecs[i].chk}};
      tick();
      #1;
      idle();
      #1;
      for (int k = 0; k < NR; k++) begin
        check($sformatf("vec%0d data[%0d]", i, k), rd_data[k*DW +: DW], vecs[i].exp_data);
        check($sformatf("vec%0d pend[%0d]", i, k), {31'd0, rd_pending[k]}, {31'd0, vecs[i].exp_pend});
      end
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
    end

    // Asynchronous reset between edges while r1=5 is pending
    @(negedge clk);
    rd_addr = {NR{4'd1}};
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("async rst data[%0d]", k), rd_data[k*DW +: DW], 32'd0);
      check($sformatf("async rst pend[%0d]", k), {31'd0, rd_pending[k]}, 32'd0);
    end
    check("async rst pc", pc, 32'd0);
    model_reset();

    // A write presented while reset is held is lost
    wr_en = 2'b01; wr_addr0 = 4'd7; wr_data0 = 32'd77; rd_addr = {NR{4'd7}};
    @(posedge clk);
    #1;
    check("write during reset", rd_data[DW-1:0], 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Write r5 while reading r5 in the same cycle
    @(negedge clk);
    wr_en = 2'b01; wr_addr0 = 4'd5; wr_data0 = 32'd33; rd_addr = {NR{4'd5}};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'd33;
`else
    exp_byp = 32'd0;
`endif
    check("same-cycle read r5", rd_data[DW-1:0], exp_byp);
    tick();
    #1;
    idle();
    #1;
    check("post-edge read r5", rd_data[DW-1:0], 32'd33);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wr_en    = 2'($urandom);
      wr_addr0 = 4'($urandom);
      wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 4'($urandom);
      wr_data0 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      wr_data1 = $urandom;
      pc_inc   = 1'($urandom);
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr1 : 4'($urandom);
      for (int k = 0; k < NR; k++) begin
        rd_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr0 : 4'($urandom);
      end
      #1;
      check_ports_vs_model($sformatf("rnd%0d", n));
      tick();
    end
    @(negedge clk);
    idle();
    #1;
    check_ports_vs_model("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
